// File: rtl/data_converter.sv
// -----------------------------------------------------------------------------
// data_converter
//   Wide-to-narrow serialiser. Each accepted IN_W-bit word is emitted as
//   RATIO = IN_W/OUT_W consecutive OUT_W-bit slices, one per clock. Storage is
//   an active shift register (slice currently on data_out) plus one pending
//   word, so back-to-back words stream without gaps.
//
//   Configuration macro:
//     DATA_CONVERTER_MSB_FIRST_EN  defined   -> slices leave MSB first
//                                  undefined -> slices leave LSB first
//
//   Ports:
//     clk_in     in   1      sole clock, rising edge
//     rst_n      in   1      asynchronous active-low reset
//     valid_in   in   1      data_in carries a word this cycle
//     data_in    in   IN_W   input word
//     ready_in   out  1      word accepted when valid_in && ready_in at an edge
//     valid_out  out  1      data_out carries a slice this cycle
//     data_out   out  OUT_W  current slice, 0 while valid_out is low
//     last_out   out  1      final slice of the word
//     overflow   out  1      sticky: a word arrived while ready_in was low
// -----------------------------------------------------------------------------
module data_converter #(
  parameter int IN_W  = 64,
  parameter int OUT_W = 8
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic [IN_W-1:0]  data_in,
  output logic             ready_in,
  output logic             valid_out,
  output logic [OUT_W-1:0] data_out,
  output logic             last_out,
  output logic             overflow
);

  localparam int RATIO = IN_W / OUT_W;
  localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(RATIO - 1);

  logic [IN_W-1:0]  act_q,  act_d;
  logic             act_vld_q, act_vld_d;
  logic [CNT_W-1:0] cnt_q,  cnt_d;
  logic [IN_W-1:0]  pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             last_q, last_d;
  logic             overflow_q, overflow_d;

  logic             accept;
  logic             act_free;
  logic [IN_W-1:0]  act_shifted;

  // Only pending occupancy gates the input; valid_in never feeds back.
  assign ready_in = ~pend_vld_q;
  assign accept   = valid_in & ~pend_vld_q;
  // Active register can take a new word this edge: empty or on its last slice.
  assign act_free = ~act_vld_q | (cnt_q == LAST_SLICE);

  // The outgoing slice always sits at the output end of act_q; shifting pulls
  // zeros in so act_q is all-zero whenever it is empty.
`ifdef DATA_CONVERTER_MSB_FIRST_EN
  assign act_shifted = act_q << OUT_W;
  assign data_out    = act_q[IN_W-1 -: OUT_W];
`else
  assign act_shifted = act_q >> OUT_W;
  assign data_out    = act_q[OUT_W-1:0];
`endif

  assign valid_out = act_vld_q;
  assign last_out  = last_q;
  assign overflow  = overflow_q;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    act_d      = act_q;
    act_vld_d  = act_vld_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    overflow_d = overflow_q | (valid_in & pend_vld_q);

    if (!act_free) begin
      act_d = act_shifted;
      cnt_d = cnt_q + CNT_W'(1);
    end else if (pend_vld_q) begin
      // Pending word takes over the slot the finishing word leaves.
      act_d      = pend_q;
      act_vld_d  = 1'b1;
      cnt_d      = '0;
      pend_vld_d = 1'b0;
    end else if (accept) begin
      act_d     = data_in;
      act_vld_d = 1'b1;
      cnt_d     = '0;
    end else begin
      act_d     = '0;
      act_vld_d = 1'b0;
      cnt_d     = '0;
    end

    // Active still busy: park the new word. data_in is captured only on
    // accept, so an undriven bus while valid_in is low never reaches outputs.
    if (accept && !act_free) begin
      pend_d     = data_in;
      pend_vld_d = 1'b1;
    end

    last_d = act_vld_d && (cnt_d == LAST_SLICE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      act_q      <= '0;
      act_vld_q  <= 1'b0;
      cnt_q      <= '0;
      pend_vld_q <= 1'b0;
      last_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      act_q      <= act_d;
      act_vld_q  <= act_vld_d;
      cnt_q      <= cnt_d;
      pend_vld_q <= pend_vld_d;
      last_q     <= last_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: the pending data word carries no reset; its valid flag guards it,
  // so clearing the payload would only add reset fan-out.
  always_ff @(posedge clk_in) begin
    pend_q <= pend_d;
  end

endmodule

// File: tb/tb_data_converter.sv
// -----------------------------------------------------------------------------
// tb_data_converter
//   Self-checking bench for data_converter (default IN_W=64, OUT_W=8).
//   Directed table for the two-word/overflow stream, hand sequences for single
//   word and mid-word reset, then random traffic against a byte-queue model.
//   Honours DATA_CONVERTER_MSB_FIRST_EN for expected slice order.
// -----------------------------------------------------------------------------
module tb_data_converter;

  localparam int IN_W  = 64;
  localparam int OUT_W = 8;
  localparam int RATIO = IN_W / OUT_W;

  logic             clk_in = 1'b0;
  logic             rst_n;
  logic             valid_in;
  logic [IN_W-1:0]  data_in;
  logic             ready_in;
  logic             valid_out;
  logic [OUT_W-1:0] data_out;
  logic             last_out;
  logic             overflow;

  int n_checks = 0;
  int n_fail   = 0;

  data_converter #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .valid_in (valid_in),
    .data_in  (data_in),
    .ready_in (ready_in),
    .valid_out(valid_out),
    .data_out (data_out),
    .last_out (last_out),
    .overflow (overflow)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Byte value b of a word built from ascending bytes, as it is expected on
  // the output at the matching position in the stream.
  function automatic logic [7:0] ob(input logic [7:0] b);
`ifdef DATA_CONVERTER_MSB_FIRST_EN
    return (b & 8'h08) | (8'h07 - (b & 8'h07));
`else
    return b;
`endif
  endfunction

  function automatic logic [OUT_W-1:0] slice_of(input logic [IN_W-1:0] w, input int k);
`ifdef DATA_CONVERTER_MSB_FIRST_EN
    return w[IN_W-1-k*OUT_W -: OUT_W];
`else
    return w[k*OUT_W +: OUT_W];
`endif
  endfunction

  // ---------------- reference model: queue of outstanding bytes -------------
  typedef struct { logic [OUT_W-1:0] b; logic last; } byte_t;
  byte_t m_q[$];
  logic  m_ovf;

  function automatic logic m_ready();
    // A word waits in pending exactly when more than one word's worth of
    // bytes is still outstanding.
    return m_q.size() <= RATIO;
  endfunction

  task automatic model_edge(input logic v, input logic [IN_W-1:0] d);
    logic rdy;
    rdy = m_ready();
    if (m_q.size() > 0) void'(m_q.pop_front());
    if (v && rdy) begin
      for (int k = 0; k < RATIO; k++) m_q.push_back('{slice_of(d, k), k == RATIO-1});
    end else if (v) begin
      m_ovf = 1'b1;
    end
  endtask

  task automatic model_check(input int cyc);
    logic             ev = m_q.size() > 0;
    logic [OUT_W-1:0] ed = ev ? m_q[0].b : '0;
    logic             el = ev ? m_q[0].last : 1'b0;
    check($sformatf("rnd%0d valid", cyc), 64'(valid_out), 64'(ev));
    check($sformatf("rnd%0d data",  cyc), 64'(data_out),  64'(ed));
    check($sformatf("rnd%0d last",  cyc), 64'(last_out),  64'(el));
    check($sformatf("rnd%0d ready", cyc), 64'(ready_in),  64'(m_ready()));
    check($sformatf("rnd%0d ovf",   cyc), 64'(overflow),  64'(m_ovf));
  endtask

  // Inputs are set after a negedge, the edge applies them, outputs are
  // sampled on the following negedge.
  task automatic cycle(input logic v, input logic [IN_W-1:0] d);
    valid_in = v;
    data_in  = d;
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    valid_in = 1'b0;
    data_in  = '0;
    repeat (2) @(negedge clk_in);
    rst_n = 1'b1;
    m_q.delete();
    m_ovf = 1'b0;
  endtask

  task automatic check_outs(input string tag, input logic v, input logic [7:0] d,
                            input logic l, input logic r, input logic o);
    check({tag, " valid"}, 64'(valid_out), 64'(v));
    check({tag, " data"},  64'(data_out),  64'(d));
    check({tag, " last"},  64'(last_out),  64'(l));
    check({tag, " ready"}, 64'(ready_in),  64'(r));
    check({tag, " ovf"},   64'(overflow),  64'(o));
  endtask

  typedef struct {
    logic            v;
    logic [IN_W-1:0] d;
    logic            ev;
    logic [7:0]      ed;
    logic            el;
    logic            er;
    logic            eo;
  } vec_t;

  localparam logic [IN_W-1:0] WA = 64'h0706050403020100;
  localparam logic [IN_W-1:0] WB = 64'h0F0E0D0C0B0A0908;
  localparam logic [IN_W-1:0] WC = 64'hDEADBEEFCAFEF00D;

  initial begin
    vec_t vecs[17];
    logic [IN_W-1:0] w;

    // Two words back to back, a third dropped while pending is full.
    vecs[0]  = '{1'b1, WA, 1'b1, ob(8'h00), 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, WB, 1'b1, ob(8'h01), 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, WC, 1'b1, ob(8'h02), 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, '0, 1'b1, ob(8'h03), 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, '0, 1'b1, ob(8'h04), 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, '0, 1'b1, ob(8'h05), 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, '0, 1'b1, ob(8'h06), 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, '0, 1'b1, ob(8'h07), 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, '0, 1'b1, ob(8'h08), 1'b0, 1'b1, 1'b1};
    vecs[9]  = '{1'b0, '0, 1'b1, ob(8'h09), 1'b0, 1'b1, 1'b1};
    vecs[10] = '{1'b0, '0, 1'b1, ob(8'h0A), 1'b0, 1'b1, 1'b1};
    vecs[11] = '{1'b0, '0, 1'b1, ob(8'h0B), 1'b0, 1'b1, 1'b1};
    vecs[12] = '{1'b0, '0, 1'b1, ob(8'h0C), 1'b0, 1'b1, 1'b1};
    vecs[13] = '{1'b0, '0, 1'b1, ob(8'h0D), 1'b0, 1'b1, 1'b1};
    vecs[14] = '{1'b0, '0, 1'b1, ob(8'h0E), 1'b0, 1'b1, 1'b1};
    vecs[15] = '{1'b0, '0, 1'b1, ob(8'h0F), 1'b1, 1'b1, 1'b1};
    vecs[16] = '{1'b0, '0, 1'b0, 8'h00,     1'b0, 1'b1, 1'b1};

    // ---- reset state ----
    do_reset();
    check_outs("reset", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // ---- single word, then idle ----
    cycle(1'b1, WA);
    for (int k = 0; k < RATIO; k++) begin
      check_outs($sformatf("single%0d", k), 1'b1, ob(8'(k)), k == RATIO-1, 1'b1, 1'b0);
      cycle(1'b0, 'x);
    end
    check_outs("single_end", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // ---- directed table ----
    do_reset();
    for (int i = 0; i < 17; i++) begin
      cycle(vecs[i].v, vecs[i].d);
      check_outs($sformatf("tbl%0d", i), vecs[i].ev, vecs[i].ed, vecs[i].el,
                 vecs[i].er, vecs[i].eo);
    end

    // ---- asynchronous reset during slice 3 ----
    cycle(1'b1, WA);
    cycle(1'b1, WB);
    cycle(1'b1, WC);
    cycle(1'b0, '0);
    check("pre_rst data", 64'(data_out), 64'(ob(8'h03)));
    check("pre_rst ovf",  64'(overflow), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check_outs("async_rst", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    @(negedge clk_in);
    rst_n = 1'b1;
    cycle(1'b1, 64'h1111111111111111);
    for (int k = 0; k < RATIO; k++) begin
      check_outs($sformatf("post_rst%0d", k), 1'b1, 8'h11, k == RATIO-1, 1'b1, 1'b0);
      cycle(1'b0, '0);
    end
    check_outs("post_rst_end", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // ---- random traffic against the model ----
    do_reset();
    for (int c = 0; c < 600; c++) begin
      logic v;
      v = ($urandom_range(0, 99) < ((c < 300) ? 40 : 85));
      w = {$urandom(), $urandom()};
      valid_in = v;
      data_in  = v ? w : 'x;
      @(posedge clk_in);
      model_edge(v, w);
      @(negedge clk_in);
      model_check(c);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
